// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared widths, issue-stage state encoding and ALU function codes
package alu_issue_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int FUN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [3:0] FUN_ADD = 4'b0000;
endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - DEPTH-entry command FIFO holding {a, b, fun}, count-based full/empty
module alu_cmd_fifo
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FUN_W = FUN_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_a,
    input  logic [WIDTH-1:0] push_b,
    input  logic [FUN_W-1:0] push_fun,
    input  logic             pop,
    output logic [WIDTH-1:0] head_a,
    output logic [WIDTH-1:0] head_b,
    output logic [FUN_W-1:0] head_fun,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 * WIDTH + FUN_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign {head_a, head_b, head_fun} = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_a, push_b, push_fun};
    end
endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: command FIFO, registered ALU drive, held result; ALU_XCHK_EN adds X/Z result flagging
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FUN_W = FUN_W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [FUN_W-1:0] cmd_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_c_out,
    output logic [FUN_W-1:0] res_fun,
    output logic             res_err,
    output logic             busy
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [FUN_W-1:0]   alu_fun_q, alu_fun_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_y_q, res_y_d;
    logic               res_c_out_q, res_c_out_d;
    logic [FUN_W-1:0]   res_fun_q, res_fun_d;
    logic               res_err_q, res_err_d;

    logic             fifo_full, fifo_empty, push, pop, x_err;
    logic [WIDTH-1:0] head_a, head_b;
    logic [FUN_W-1:0] head_fun;

    assign cmd_ready = rst_n && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = !fifo_empty &&
                       ((state_q == IDLE) || (state_q == HOLD && res_ready));

    alu_cmd_fifo #(.WIDTH(WIDTH), .FUN_W(FUN_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_a   (cmd_a),
        .push_b   (cmd_b),
        .push_fun (cmd_fun),
        .pop      (pop),
        .head_a   (head_a),
        .head_b   (head_b),
        .head_fun (head_fun),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef ALU_XCHK_EN
    assign x_err = ((^{alu_y, alu_c_out}) === 1'bx);

    always_ff @(posedge clk) begin
        if (state_q == DRIVE && x_err)
            $display("alu_issue_stage: X/Z ALU result fun=%h a=%h b=%h", alu_fun_q, alu_a_q, alu_b_q);
    end
`else
    assign x_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_c_out_d = res_c_out_q;
        res_fun_d   = res_fun_q;
        res_err_d   = res_err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    alu_a_d   = head_a;
                    alu_b_d   = head_b;
                    alu_fun_d = head_fun;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                res_y_d     = alu_y;
                res_c_out_d = alu_c_out;
                res_fun_d   = alu_fun_q;
                res_err_d   = x_err;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    if (pop) begin
                        alu_a_d   = head_a;
                        alu_b_d   = head_b;
                        alu_fun_d = head_fun;
                        state_d   = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_c_out_q <= 1'b0;
            res_fun_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_c_out_q <= res_c_out_d;
            res_fun_q   <= res_fun_d;
            res_err_q   <= res_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_c_out = res_c_out_q;
    assign res_fun   = res_fun_q;
    assign res_err   = res_err_q;
    assign busy      = !fifo_empty || (state_q != IDLE);
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU attached
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_fun;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_fun;
    logic        alu_c_out;
    logic        res_valid, res_ready, res_c_out, res_err, busy;
    logic [31:0] res_y;
    logic [3:0]  res_fun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_y(alu_y), .alu_c_out(alu_c_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_c_out(res_c_out), .res_fun(res_fun),
        .res_err(res_err), .busy(busy)
    );

    // Team ALU behaviour: returns {c_out, y}
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] fun);
        case (fun)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {(a < b), a - b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {a[31], a << 1};
            4'd6:    return {a[0], a >> 1};
            4'd7:    return {1'b0, b};
            default: return 33'd0;
        endcase
    endfunction

    always_comb {alu_c_out, alu_y} = alu_model(alu_a, alu_b, alu_fun);

    typedef struct {
        logic [3:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fun;
    } cmd_t;

    vec_t vecs[8];
    cmd_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string name, input int budget);
        int n = 0;
        while (!res_valid && n < budget) begin
            tick();
            n++;
        end
        check({name, "_res_valid_timeout"}, 64'(res_valid), 64'd1);
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fun);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [32:0] r;
        int cyc, k, pushed, last_cyc, stale, n;
        cmd_t c;

        vecs[0] = '{4'd0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
        vecs[1] = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
        vecs[2] = '{4'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1};
        vecs[3] = '{4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[4] = '{4'd3, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
        vecs[5] = '{4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
        vecs[6] = '{4'd5, 32'h80000001, 32'h00000000, 32'h00000002, 1'b1};
        vecs[7] = '{4'd6, 32'h00000003, 32'h00000000, 32'h00000001, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fun = '0; res_ready = 1'b0;
        tick(); tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_alu_a",     64'(alu_a),     64'd0);
        check("rst_alu_fun",   64'(alu_fun),   64'd0);
        check("rst_res_y",     64'(res_y),     64'd0);
        check("rst_res_err",   64'(res_err),   64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Table: single op from an idle stage, latency E1 drive / E2 result
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_cmd(vecs[i].a, vecs[i].b, vecs[i].fun);
            check("vec_cmd_ready", 64'(cmd_ready), 64'd1);
            tick();
            cmd_valid = 1'b0;
            check("vec_e0_res_valid", 64'(res_valid), 64'd0);
            tick();
            check("vec_e1_res_valid", 64'(res_valid), 64'd0);
            check("vec_e1_alu_a",     64'(alu_a),     64'(vecs[i].a));
            check("vec_e1_alu_b",     64'(alu_b),     64'(vecs[i].b));
            check("vec_e1_alu_fun",   64'(alu_fun),   64'(vecs[i].fun));
            tick();
            check("vec_e2_res_valid", 64'(res_valid), 64'd1);
            check("vec_res_y",        64'(res_y),     64'(vecs[i].y));
            check("vec_res_c_out",    64'(res_c_out), 64'(vecs[i].c));
            check("vec_res_fun",      64'(res_fun),   64'(vecs[i].fun));
            tick();
            check("vec_e3_res_valid", 64'(res_valid), 64'd0);
            check("vec_e3_busy",      64'(busy),      64'd0);
            check("vec_alu_hold",     64'(alu_a),     64'(vecs[i].a));
        end

        // Fill under backpressure: 1 in HOLD + 4 queued
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(32'd100 + 32'(i), 32'(i), 4'd0);
            check("bp_cmd_ready_fill", 64'(cmd_ready), 64'd1);
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_full_cmd_ready", 64'(cmd_ready), 64'd0);
        tick(); tick();
        check("bp_hold_valid",     64'(res_valid), 64'd1);
        check("bp_hold_y",         64'(res_y),     64'd100);
        check("bp_still_full",     64'(cmd_ready), 64'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res("bp", 10);
            check("bp_res_y", 64'(res_y), 64'(32'd100 + 32'(2 * i)));
            tick();
            if (i == 0) check("bp_cmd_ready_after_pop", 64'(cmd_ready), 64'd1);
        end
        check("bp_busy_end", 64'(busy), 64'd0);

        // Back-to-back 8 commands, res_ready tied high
        res_ready = 1'b1;
        cyc = 0; k = 0; pushed = 0; last_cyc = 0;
        while (k < 8 && cyc < 200) begin
            if (res_valid) begin
                r = alu_model(32'(k), 32'(k), 4'(k % 8));
                check("b2b_res_y",     64'(res_y),     64'(r[31:0]));
                check("b2b_res_c_out", 64'(res_c_out), 64'(r[32]));
                check("b2b_res_fun",   64'(res_fun),   64'(k % 8));
                if (k > 0) check("b2b_spacing", 64'(cyc - last_cyc), 64'd2);
                last_cyc = cyc;
                k++;
            end
            if (pushed < 8) push_cmd(32'(pushed), 32'(pushed), 4'(pushed % 8));
            else cmd_valid = 1'b0;
            if (cmd_valid && cmd_ready) pushed++;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        check("b2b_count", 64'(k), 64'd8);
        check("b2b_busy_end", 64'(busy), 64'd0);

        // Asynchronous reset while HOLD with two queued
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(32'h55 + 32'(i), 32'h1, 4'd0);
            tick();
        end
        cmd_valid = 1'b0;
        wait_res("rstmid", 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_res_valid", 64'(res_valid), 64'd0);
        check("rstmid_busy",      64'(busy),      64'd0);
        check("rstmid_alu_a",     64'(alu_a),     64'd0);
        check("rstmid_alu_b",     64'(alu_b),     64'd0);
        check("rstmid_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            tick();
            if (res_valid || busy) stale++;
        end
        check("rstmid_no_stale", 64'(stale), 64'd0);

        // X/Z operands
        push_cmd('x, 'x, 4'd0);
        tick();
        cmd_valid = 1'b0;
        wait_res("xz", 10);
`ifdef ALU_XCHK_EN
        check("xz_res_err", 64'(res_err), 64'd1);
`else
        check("xz_res_err", 64'(res_err), 64'd0);
`endif
        tick();
        check("xz_err_cleared", 64'(res_err), 64'd0);

        // Random traffic against a queue scoreboard
        for (int i = 0; i < 600; i++) begin
            res_ready = 1'($urandom_range(0, 1));
            if (res_valid && res_ready) begin
                if (model_q.size() == 0) begin
                    check("rnd_unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    c = model_q.pop_front();
                    r = alu_model(c.a, c.b, c.fun);
                    check("rnd_res_y",     64'(res_y),     64'(r[31:0]));
                    check("rnd_res_c_out", 64'(res_c_out), 64'(r[32]));
                    check("rnd_res_fun",   64'(res_fun),   64'(c.fun));
                end
            end
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a     = $urandom;
            cmd_b     = $urandom;
            cmd_fun   = 4'($urandom_range(0, 7));
            if (cmd_valid && cmd_ready) model_q.push_back('{cmd_a, cmd_b, cmd_fun});
            tick();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        n = 0;
        while ((model_q.size() > 0 || busy) && n < 100) begin
            if (res_valid && model_q.size() > 0) begin
                c = model_q.pop_front();
                r = alu_model(c.a, c.b, c.fun);
                check("drain_res_y",   64'(res_y),   64'(r[31:0]));
                check("drain_res_fun", 64'(res_fun), 64'(c.fun));
            end
            tick();
            n++;
        end
        check("drain_model_empty", 64'(model_q.size()), 64'd0);
        check("drain_busy",        64'(busy),           64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
